// File: rtl/ec_fe12_mul_drv.sv
// -----------------------------------------------------------------------------
// ec_fe12_mul_drv
//
// Purpose:
//   Adapts a parallel Fp12 multiply request (twelve Fp elements for each operand)
//   to the beat-serial streams used by the fe12 multiplier. It also rebuilds the
//   parallel product from the multiplier's result stream. Only one transaction
//   is in flight at a time.
//
//   IDLE : o_req_rdy high. A request handshake captures a, b and ctl.
//   BUSY : Twelve operand beats {b[n], a[n]} go out on the mul stream.
//          Twelve result beats are collected on the res stream at the same time.
//          Result beats may start before all operand beats have been sent.
//   DONE : The assembled product, tag and framing-error flag are held
//          until the consumer accepts them.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_req_val/o_req_rdy          request handshake
//   i_req_a, i_req_b             operands, element n at [n*FE_BITS +: FE_BITS]
//   i_req_ctl                    request tag
//   o_mul_val/sop/eop, i_mul_rdy operand stream to the multiplier
//   o_mul_dat                    beat n = {b[n], a[n]}
//   o_mul_ctl                    captured tag, present on every operand beat
//   i_res_val/sop/eop, o_res_rdy result stream from the multiplier
//   i_res_dat                    result element for beat n
//   o_out_val/i_out_rdy          product handshake
//   o_out_dat                    product, element n at [n*FE_BITS +: FE_BITS]
//   o_out_ctl                    tag of the request
//   o_out_err                    framing error seen on the result stream
// -----------------------------------------------------------------------------
module ec_fe12_mul_drv #(
    parameter int FE_BITS  = 381,
    parameter int CTL_BITS = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,

    input  logic                    i_req_val,
    output logic                    o_req_rdy,
    input  logic [12*FE_BITS-1:0]   i_req_a,
    input  logic [12*FE_BITS-1:0]   i_req_b,
    input  logic [CTL_BITS-1:0]     i_req_ctl,

    output logic                    o_mul_val,
    output logic                    o_mul_sop,
    output logic                    o_mul_eop,
    input  logic                    i_mul_rdy,
    output logic [2*FE_BITS-1:0]    o_mul_dat,
    output logic [CTL_BITS-1:0]     o_mul_ctl,

    input  logic                    i_res_val,
    input  logic                    i_res_sop,
    input  logic                    i_res_eop,
    output logic                    o_res_rdy,
    input  logic [FE_BITS-1:0]      i_res_dat,

    output logic                    o_out_val,
    input  logic                    i_out_rdy,
    output logic [12*FE_BITS-1:0]   o_out_dat,
    output logic [CTL_BITS-1:0]     o_out_ctl,
    output logic                    o_out_err
);

    localparam int         NUM_EL    = 12;
    localparam logic [3:0] LAST_BEAT = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic                req_rdy_reg;

    logic [3:0]          tx_cnt_reg;
    logic                tx_done_reg;
    logic [3:0]          rx_cnt_reg;
    logic                rx_done_reg;
    logic                err_reg;

    logic [FE_BITS-1:0]  a_reg   [NUM_EL];
    logic [FE_BITS-1:0]  b_reg   [NUM_EL];
    logic [FE_BITS-1:0]  res_reg [NUM_EL];
    logic [CTL_BITS-1:0] ctl_reg;

    logic                req_fire;
    logic                mul_fire;
    logic                res_fire;
    logic                out_fire;
    logic                frame_err;

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    assign req_fire = i_req_val & req_rdy_reg;
    assign mul_fire = o_mul_val & i_mul_rdy;
    assign res_fire = i_res_val & o_res_rdy;
    assign out_fire = o_out_val & i_out_rdy;

    // A beat is malformed if sop disagrees with "first beat" or eop disagrees
    // with "last beat". Both directions count: a missing marker is an error,
    // and a marker on the wrong beat is also an error.
    assign frame_err = (i_res_sop != (rx_cnt_reg == 4'd0)) |
                       (i_res_eop != (rx_cnt_reg == LAST_BEAT));

    // ------------------------------------------------------------------
    // FSM state register.
    // o_req_rdy is registered rather than decoded from the state, so it stays
    // low during reset. It rises on the first clock after reset is released.
    // Outside reset it equals (state == IDLE).
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            req_rdy_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            req_rdy_reg <= (state_next == ST_IDLE);
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and stream outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        o_mul_val  = 1'b0;
        o_res_rdy  = 1'b0;
        o_out_val  = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (req_fire) begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                o_mul_val = ~tx_done_reg;
                o_res_rdy = ~rx_done_reg;
                // The done flags are registered, so DONE is entered one
                // cycle after the later of the two streams finishes.
                if (tx_done_reg && rx_done_reg) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_out_val = 1'b1;
                if (out_fire) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_req_rdy = req_rdy_reg;

    // ------------------------------------------------------------------
    // Operand (tx) beat counter.
    // The counter holds at the last beat once it is done. The sop/eop decodes
    // are gated by o_mul_val, so the held count never shows on the stream.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_cnt_reg  <= 4'd0;
            tx_done_reg <= 1'b0;
        end else if (req_fire) begin
            tx_cnt_reg  <= 4'd0;
            tx_done_reg <= 1'b0;
        end else if (mul_fire) begin
            if (tx_cnt_reg == LAST_BEAT) begin
                tx_done_reg <= 1'b1;
            end else begin
                tx_cnt_reg <= tx_cnt_reg + 4'd1;
            end
        end
    end

    assign o_mul_sop = o_mul_val & (tx_cnt_reg == 4'd0);
    assign o_mul_eop = o_mul_val & (tx_cnt_reg == LAST_BEAT);
    assign o_mul_dat = {b_reg[tx_cnt_reg], a_reg[tx_cnt_reg]};
    assign o_mul_ctl = ctl_reg;

    // ------------------------------------------------------------------
    // Result (rx) beat counter and sticky framing error.
    // Framing errors never disturb the count. The transaction always ends
    // after exactly twelve accepted result beats.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_cnt_reg  <= 4'd0;
            rx_done_reg <= 1'b0;
        end else if (req_fire) begin
            rx_cnt_reg  <= 4'd0;
            rx_done_reg <= 1'b0;
        end else if (res_fire) begin
            if (rx_cnt_reg == LAST_BEAT) begin
                rx_done_reg <= 1'b1;
            end else begin
                rx_cnt_reg <= rx_cnt_reg + 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_reg <= 1'b0;
        end else if (req_fire || out_fire) begin
            err_reg <= 1'b0;
        end else if (res_fire && frame_err) begin
            err_reg <= 1'b1;
        end
    end

    assign o_out_err = err_reg;
    assign o_out_ctl = ctl_reg;

    // ------------------------------------------------------------------
    // Data path: operand capture, result assembly and output packing.
    // These registers have no reset. They are only observed while the FSM
    // marks them valid, and a reset clears the FSM and counters.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (req_fire) begin
            ctl_reg <= i_req_ctl;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_EL; gi++) begin : g_elem
            always_ff @(posedge i_clk) begin
                if (req_fire) begin
                    a_reg[gi] <= i_req_a[gi*FE_BITS +: FE_BITS];
                    b_reg[gi] <= i_req_b[gi*FE_BITS +: FE_BITS];
                end
                if (res_fire && (rx_cnt_reg == 4'(gi))) begin
                    res_reg[gi] <= i_res_dat;
                end
            end

            assign o_out_dat[gi*FE_BITS +: FE_BITS] = res_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_ec_fe12_mul_drv.sv
// -----------------------------------------------------------------------------
// tb_ec_fe12_mul_drv
//
// Purpose:
//   Self-checking bench for ec_fe12_mul_drv with FE_BITS=32.
//   A behavioural fe12 multiplier answers each operand beat with
//   a[n]*b[n] mod P, where P = 2^32-5. Its response can be delayed, and it
//   can inject a framing error. Expected products are computed directly from
//   the stimulus with plain modular arithmetic.
// -----------------------------------------------------------------------------
module tb_ec_fe12_mul_drv;

    localparam int          FE = 32;
    localparam int          CW = 32;
    localparam int          NE = 12;
    localparam logic [63:0] P  = 64'd4294967291;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req_val;
    logic              o_req_rdy;
    logic [NE*FE-1:0]  i_req_a;
    logic [NE*FE-1:0]  i_req_b;
    logic [CW-1:0]     i_req_ctl;
    logic              o_mul_val, o_mul_sop, o_mul_eop;
    logic              i_mul_rdy;
    logic [2*FE-1:0]   o_mul_dat;
    logic [CW-1:0]     o_mul_ctl;
    logic              i_res_val, i_res_sop, i_res_eop;
    logic              o_res_rdy;
    logic [FE-1:0]     i_res_dat;
    logic              o_out_val;
    logic              i_out_rdy;
    logic [NE*FE-1:0]  o_out_dat;
    logic [CW-1:0]     o_out_ctl;
    logic              o_out_err;

    ec_fe12_mul_drv #(.FE_BITS(FE), .CTL_BITS(CW)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req_val (i_req_val),
        .o_req_rdy (o_req_rdy),
        .i_req_a   (i_req_a),
        .i_req_b   (i_req_b),
        .i_req_ctl (i_req_ctl),
        .o_mul_val (o_mul_val),
        .o_mul_sop (o_mul_sop),
        .o_mul_eop (o_mul_eop),
        .i_mul_rdy (i_mul_rdy),
        .o_mul_dat (o_mul_dat),
        .o_mul_ctl (o_mul_ctl),
        .i_res_val (i_res_val),
        .i_res_sop (i_res_sop),
        .i_res_eop (i_res_eop),
        .o_res_rdy (o_res_rdy),
        .i_res_dat (i_res_dat),
        .o_out_val (o_out_val),
        .i_out_rdy (i_out_rdy),
        .o_out_dat (o_out_dat),
        .o_out_ctl (o_out_ctl),
        .o_out_err (o_out_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [FE-1:0] mulmod(input logic [FE-1:0] x, input logic [FE-1:0] y);
        logic [63:0] prod;
        prod = {32'd0, x} * {32'd0, y};
        return FE'(prod % P);
    endfunction

    // ------------------------------------------------------------------
    // Behavioural fe12 multiplier.
    // Result beat k is returned only after operand beat k has been received,
    // and only once at least res_lag operand beats have been received.
    // ------------------------------------------------------------------
    logic [63:0] ops_q[$];
    logic        sop_q[$];
    logic        eop_q[$];
    int          res_idx    = 0;
    int          res_lag    = 0;
    int          eop_beat   = NE - 1;
    bit          toggle_rdy = 1'b0;
    logic [63:0] stall_dat;
    logic [1:0]  stall_se;
    logic        stall_flag = 1'b0;

    initial begin : mul_model
        i_mul_rdy = 1'b0;
        i_res_val = 1'b0;
        i_res_sop = 1'b0;
        i_res_eop = 1'b0;
        i_res_dat = '0;
        forever begin
            @(negedge clk);
            if (rst || (o_req_rdy && i_req_val)) begin
                ops_q.delete();
                sop_q.delete();
                eop_q.delete();
                res_idx    = 0;
                stall_flag = 1'b0;
            end else begin
                if (stall_flag) begin
                    check("stall_val", o_mul_val, 1);
                    check("stall_dat", o_mul_dat, stall_dat);
                    check("stall_sop_eop", {o_mul_sop, o_mul_eop}, stall_se);
                end
                if (res_idx == NE) begin
                    check("res_rdy_drop", o_res_rdy, 0);
                end
                if (o_mul_val && i_mul_rdy) begin
                    ops_q.push_back(o_mul_dat);
                    sop_q.push_back(o_mul_sop);
                    eop_q.push_back(o_mul_eop);
                end
                stall_flag = o_mul_val && !i_mul_rdy;
                stall_dat  = o_mul_dat;
                stall_se   = {o_mul_sop, o_mul_eop};
                if (i_res_val && o_res_rdy) begin
                    res_idx++;
                end
            end
            @(posedge clk);
            #1;
            i_mul_rdy = toggle_rdy ? !i_mul_rdy : 1'b1;
            if (!rst && res_idx < NE && ops_q.size() > res_idx && ops_q.size() >= res_lag) begin
                i_res_val = 1'b1;
                i_res_sop = (res_idx == 0);
                i_res_eop = (res_idx == eop_beat);
                i_res_dat = mulmod(ops_q[res_idx][FE-1:0], ops_q[res_idx][2*FE-1:FE]);
            end else begin
                i_res_val = 1'b0;
                i_res_sop = 1'b0;
                i_res_eop = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transaction helpers. Every task is entered just after a rising edge.
    // ------------------------------------------------------------------
    logic [FE-1:0] a_v [NE];
    logic [FE-1:0] b_v [NE];
    logic [CW-1:0] ctl_v;

    task automatic randomize_req();
        for (int n = 0; n < NE; n++) begin
            a_v[n] = $urandom_range(32'hFFFFFFFA, 0);
            b_v[n] = $urandom_range(32'hFFFFFFFA, 0);
        end
        ctl_v = $urandom;
    endtask

    task automatic send_req();
        int waited = 0;
        for (int n = 0; n < NE; n++) begin
            i_req_a[n*FE +: FE] = a_v[n];
            i_req_b[n*FE +: FE] = b_v[n];
        end
        i_req_ctl = ctl_v;
        i_req_val = 1'b1;
        @(negedge clk);
        while (!o_req_rdy && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        check("req_rdy_timeout", o_req_rdy, 1);
        @(posedge clk);
        #1;
        i_req_val = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!o_out_val && lat < 300);
        check("done_timeout", o_out_val, 1);
    endtask

    task automatic check_result(input logic exp_err);
        check("out_ctl", o_out_ctl, ctl_v);
        check("out_err", o_out_err, exp_err);
        check("res_beats", res_idx, NE);
        check("op_beats", ops_q.size(), NE);
        for (int n = 0; n < NE; n++) begin
            check($sformatf("out_dat[%0d]", n), o_out_dat[n*FE +: FE], mulmod(a_v[n], b_v[n]));
            if (n < ops_q.size()) begin
                check($sformatf("op_dat[%0d]", n), ops_q[n], {b_v[n], a_v[n]});
                check($sformatf("op_sop_eop[%0d]", n), {sop_q[n], eop_q[n]}, {n == 0, n == NE - 1});
            end
        end
    endtask

    // Called at a negedge in DONE with i_out_rdy high.
    task automatic finish_txn();
        @(posedge clk);
        #1;
        @(negedge clk);
        check("req_rdy_after_done", o_req_rdy, 1);
        check("out_val_after_done", o_out_val, 0);
        check("err_cleared", o_out_err, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic exp_err, input bit chk_lat, input int exp_lat);
        int lat;
        send_req();
        wait_done(lat);
        if (chk_lat) begin
            check("latency", lat, exp_lat);
        end
        check_result(exp_err);
        finish_txn();
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin : main
        int            lat;
        int            waited;
        logic [NE*FE-1:0] snap;

        rst       = 1'b1;
        i_req_val = 1'b0;
        i_req_a   = '0;
        i_req_b   = '0;
        i_req_ctl = '0;
        i_out_rdy = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_rdy", o_req_rdy, 0);
        check("rst_mul_val", o_mul_val, 0);
        check("rst_mul_sop_eop", {o_mul_sop, o_mul_eop}, 2'b00);
        check("rst_res_rdy", o_res_rdy, 0);
        check("rst_out_val", o_out_val, 0);
        check("rst_out_err", o_out_err, 0);
        rst = 1'b0;
        @(negedge clk);
        check("req_rdy_pre", o_req_rdy, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("req_rdy_post", o_req_rdy, 1);
        @(posedge clk);
        #1;

        // a=1, b=2, ctl=5 with all ready signals high. Also checks the minimum latency.
        for (int n = 0; n < NE; n++) begin
            a_v[n] = 32'd1;
            b_v[n] = 32'd2;
        end
        ctl_v = 32'h5;
        run_txn(1'b0, 1'b1, 15);

        // Operand stream stalled on alternate cycles
        randomize_req();
        toggle_rdy = 1'b1;
        run_txn(1'b0, 1'b0, 0);
        toggle_rdy = 1'b0;

        // Results start only after three operand beats have been sent
        randomize_req();
        res_lag = 3;
        run_txn(1'b0, 1'b0, 0);
        res_lag = 0;

        // eop on result beat 10 sets the error flag; the next clean transaction clears it
        randomize_req();
        eop_beat = 10;
        run_txn(1'b1, 1'b0, 0);
        eop_beat = NE - 1;
        randomize_req();
        run_txn(1'b0, 1'b0, 0);

        // Consumer holds off for 20 cycles in DONE
        randomize_req();
        i_out_rdy = 1'b0;
        send_req();
        wait_done(lat);
        snap = o_out_dat;
        for (int i = 0; i < 20; i++) begin
            check("hold_out_val", o_out_val, 1);
            check("hold_out_dat", o_out_dat === snap, 1);
            check("hold_req_rdy", o_req_rdy, 0);
            check("hold_mul_val", o_mul_val, 0);
            @(negedge clk);
        end
        i_out_rdy = 1'b1;
        check_result(1'b0);
        finish_txn();

        // Reset after operand beat 5 is accepted
        randomize_req();
        send_req();
        waited = 0;
        while (ops_q.size() < 6 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("beat5_timeout", ops_q.size() >= 6, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_req_rdy", o_req_rdy, 0);
        check("mid_rst_mul_val", o_mul_val, 0);
        check("mid_rst_mul_sop_eop", {o_mul_sop, o_mul_eop}, 2'b00);
        check("mid_rst_res_rdy", o_res_rdy, 0);
        check("mid_rst_out_val", o_out_val, 0);
        check("mid_rst_out_err", o_out_err, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rel_req_rdy_pre", o_req_rdy, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rel_req_rdy_post", o_req_rdy, 1);
        @(posedge clk);
        #1;
        randomize_req();
        run_txn(1'b0, 1'b0, 0);

        // Random mix of result lag and operand stalls
        for (int t = 0; t < 4; t++) begin
            randomize_req();
            res_lag    = $urandom_range(NE, 0);
            toggle_rdy = $urandom_range(1, 0);
            run_txn(1'b0, 1'b0, 0);
        end
        res_lag    = 0;
        toggle_rdy = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ec_fe12_mul_drv.md
EC_FE12_MUL_DRV -- requirements
Module: ec_fe12_mul_drv

Interface
REQ-001 Parameter FE_BITS, default 381, width of one Fp element.
REQ-002 Parameter CTL_BITS, default 32, width of the sideband ctl field.
REQ-003 i_clk  in  1  sole clock; all logic is on the rising edge.
REQ-004 i_rst  in  1  asynchronous, active-high reset.
REQ-005 i_req_val  in  1  parallel request valid.
REQ-006 o_req_rdy  out  1  request accepted when high with i_req_val.
REQ-007 i_req_a  in  12*FE_BITS  operand a; element n at [n*FE_BITS +: FE_BITS], n = i*6+j*2+k.
REQ-008 i_req_b  in  12*FE_BITS  operand b; same packing.
REQ-009 i_req_ctl  in  CTL_BITS  request tag.
REQ-010 o_mul_val, o_mul_sop, o_mul_eop  out  1 each  operand stream to the fe12 multiplier.
REQ-011 i_mul_rdy  in  1  operand stream ready.
REQ-012 o_mul_dat  out  2*FE_BITS  beat n = {b[n], a[n]}.
REQ-013 o_mul_ctl  out  CTL_BITS  captured request tag on every beat.
REQ-014 i_res_val, i_res_sop, i_res_eop  in  1 each  result stream from the multiplier.
REQ-015 o_res_rdy  out  1  result stream ready.
REQ-016 i_res_dat  in  FE_BITS  result element for beat n.
REQ-017 o_out_val  out  1  assembled product valid.
REQ-018 i_out_rdy  in  1  product consumer ready.
REQ-019 o_out_dat  out  12*FE_BITS  product; element n at [n*FE_BITS +: FE_BITS].
REQ-020 o_out_ctl  out  CTL_BITS  tag of the request.
REQ-021 o_out_err  out  1  framing error seen on the result stream.

Function
REQ-022 FSM states are IDLE, BUSY and DONE, with one transaction in flight at a time.
REQ-023 o_req_rdy is 1 only in IDLE; a handshake captures a, b and ctl into registers and moves the FSM to BUSY.
REQ-024 In BUSY, tx counter 0..11 drives o_mul_val=1 and o_mul_dat = beat tx; sop=1 on beat 0 and eop=1 on beat 11.
REQ-025 tx advances only on o_mul_val&i_mul_rdy; o_mul_dat, sop, eop and ctl are held stable while stalled.
REQ-026 After beat 11 is accepted, o_mul_val goes low until the next transaction.
REQ-027 rx counter 0..11 runs independently of tx: result beats may arrive while operand beats are still being sent.
REQ-028 o_res_rdy=1 in BUSY while fewer than 12 result beats have been received, and 0 otherwise.
REQ-029 Each accepted result beat is written to element rx of the output register.
REQ-030 o_out_err is sticky per transaction and sets on any of: sop with rx!=0, missing sop at rx==0, eop with rx!=11, missing eop at rx==11.
REQ-031 Framing errors do not alter rx counting; the transaction completes after 12 accepted result beats regardless.
REQ-032 BUSY moves to DONE in the cycle after both 12 tx beats and 12 rx beats are complete.
REQ-033 In DONE, o_out_val=1 and o_out_dat, o_out_ctl and o_out_err are held stable until i_out_rdy.
REQ-034 On the DONE handshake the FSM returns to IDLE and o_out_err clears.
REQ-035 Minimum latency with all ready signals tied high is 1 + max(12, last result beat cycle) + 1 cycles from request handshake to o_out_val.
REQ-036 Back-to-back: o_req_rdy rises in the cycle after the DONE handshake, so there is no overlap between transactions.

Reset
REQ-037 On i_rst, o_req_rdy, o_mul_val, o_mul_sop, o_mul_eop, o_res_rdy, o_out_val and o_out_err go to 0; counters go to 0; the state goes to IDLE.
REQ-038 Data and ctl registers are not reset.
REQ-039 A reset mid-transaction discards all partial data; the first request after reset deasserts is handled normally.
REQ-040 o_req_rdy goes to 1 in the first clock after reset deasserts.

Verification
REQ-041 Send a=all elements 1, b=all elements 2, ctl=0x5; use a model that returns a[n]*b[n] mod P per beat with all ready signals high -> 12 operand beats {2,1} with sop on beat 0 and eop on beat 11; o_out_dat elements all 2; o_out_ctl=0x5; o_out_err=0.
REQ-042 Toggle i_mul_rdy 1/0 every cycle -> o_mul_dat is unchanged while stalled, exactly 12 beats are sent, and the product matches REQ-041.
REQ-043 Model returns result beats starting at operand beat 3 -> the results are assembled correctly, and o_res_rdy drops after the 12th result beat.
REQ-044 Result stream has eop on beat 10 -> o_out_err=1 and the transaction completes after 12 beats; the next clean transaction gives o_out_err=0.
REQ-045 Hold i_out_rdy=0 for 20 cycles in DONE -> o_out_val and o_out_dat are stable, o_req_rdy=0, and no operand beats are sent.
REQ-046 Assert i_rst after operand beat 5 -> all valid signals are 0 within the reset; a new request then completes with the correct product.
